rf_exec_unit: RTL and testbench
===============================

# rf_exec_unit

Execute/writeback sequencer for the rudimentary processor, wrapped around the register file. It accepts one decoded instruction at a time, drives the register file's read selects, and consumes the registered A/B read data. It computes an ALU or multi-cycle multiply result, then drives D/rd/regWrite back into the register file for a single write cycle. Upstream is the decoder (valid/ready handshake); downstream and upstream on the data side is the register file.

## Interface
- BUS_WIDTH, 16, data width of A, B, D; must match the register file.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  decoder has an instruction; must hold until accepted.
- instr_ready  out  1  high only in IDLE; accept = instr_valid && instr_ready at posedge.
- opcode  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 MOV A, 7 MUL.
- rd_in / rsA_in / rsB_in  in  3 each  destination and source register indices.
- A, B  in  BUS_WIDTH  register file read data (registered in the register file, valid one edge after rsA/rsB).
- rsA, rsB  out  3  registered read selects to the register file.
- rd  out  3  registered write index.
- D  out  BUS_WIDTH  registered write data.
- regWrite  out  1  registered write enable; the register file writes on the posedge while high.
- done  out  1  high for exactly the cycle regWrite is high.
- zero, carry  out  1  result flags; update only at the commit edge.

## Operation
- FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE: instr_ready=1. On accept: latch opcode and rd_in, drive rsA/rsB from rsA_in/rsB_in, go to READ.
- READ: one wait cycle while the register file registers A/B; go to EXEC.
- EXEC, for opcodes 0-6: compute from the live A/B, register D and rd, set regWrite=1, go to WB.
- EXEC, for opcode 7: capture A and B into multiplicand/multiplier regs, clear the counter, go to MUL.
- MUL: shift-add with one multiplier bit per edge for BUS_WIDTH iterations. The last iteration edge registers D = low BUS_WIDTH bits of the product, sets regWrite=1, and goes to WB.
- WB: regWrite=1 and done=1. On the next edge (commit edge), clear regWrite, update the flags, and go to IDLE.
- Arithmetic is unsigned and modulo 2^BUS_WIDTH. Carry is defined per opcode:
  - ADD: carry-out.
  - SUB: borrow (A<B).
  - MUL: 1 if any upper product bit is nonzero.
  - Logical ops and MOV: 0.
- zero = (D == 0). B is ignored for opcodes 5 and 6.
- rd_in equal to rsA_in or rsB_in is legal: operands are read before the write.
- instr_valid while busy is ignored; no queueing.
- Reset values: instr_ready=1 once rst_n is high; rsA, rsB, rd, D = 0; regWrite, done, zero, carry = 0; state IDLE; MUL counter 0.
- Reset mid-operation clears regWrite immediately (asynchronous); no partial write occurs, and the instruction is dropped.

## Timing
- Accept at edge 0. rsA/rsB are valid after edge 0, A/B after edge 1.
- Single-cycle ops: regWrite and done are high between edge 2 and edge 3. The register file commits at edge 3, and the flags are visible after edge 3. The earliest next accept is edge 4 (4-cycle throughput).
- MUL: operands are captured at edge 2, iterations run on edges 3..2+BUS_WIDTH, and regWrite is high until commit at edge 3+BUS_WIDTH (edge 19 for width 16). The earliest next accept is edge 4+BUS_WIDTH.
- instr_ready falls the cycle after accept and returns after the commit edge.

## Structure
- Package rf_exec_pkg holds:
  - the opcode enum (3-bit);
  - the FSM state enum;
  - the REG_IDX_W=3 constant.
- Sub-module rf_exec_mul is the sequential shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, busy, last, product (2*BUS_WIDTH).
  - Started from EXEC; its last pulse triggers the WB transition.
- ALU logic stays inline in rf_exec_unit.

## Test plan
- ADD: R1=0xFFFF, R2=0x0001, accept ADD rd=3 at edge 0 -> regWrite high edge 2→3 with D=0x0000, rd=3; after edge 3 zero=1, carry=1; instr_ready low edges 1-3.
- SUB: R1=0x0000, R2=0x0001, SUB rd=4 -> D=0xFFFF, carry=1, zero=0; then AND 0xFF00&0x0FF0 -> D=0x0F00, carry=0.
- MUL: R1=0x0003, R2=0x0005, BUS_WIDTH=16 -> regWrite high only before edge 19, D=0x000F, carry=0. Then 0x0100*0x0100 -> D=0x0000, zero=1, carry=1.
- Back-to-back and busy: hold instr_valid continuously with 3 instructions -> accepts at edges 0, 4, 8. A second instruction presented at edge 1 is not accepted until edge 4, and no regWrite pulses overlap.
- Self-reference: R2=0x1234, MOV rd=2 rsA=2, then XOR rd=2 rsA=2 rsB=2 -> R2=0x1234, then 0x0000 with zero=1.
- Reset mid-MUL: deassert rst_n at edge 10 of a MUL -> regWrite, done, D, rsA, rsB, rd all 0 immediately; the destination register is unchanged, and instr_ready=1 after release.

Source files
------------

// File: rtl/rf_exec_pkg.sv
// Shared types for the execute/writeback sequencer: opcodes, FSM states, index width.
package rf_exec_pkg;

  localparam int REG_IDX_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_MOV = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MUL  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/rf_exec_if.sv
// Decoder handshake plus register-file read/write bus seen by the execute unit.
interface rf_exec_if #(parameter int BUS_WIDTH = 16);

  logic                                 instr_valid;
  logic                                 instr_ready;
  logic [2:0]                           opcode;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rd_in;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rsA_in;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rsB_in;
  logic [BUS_WIDTH-1:0]                 A;
  logic [BUS_WIDTH-1:0]                 B;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rsA;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rsB;
  logic [rf_exec_pkg::REG_IDX_W-1:0]    rd;
  logic [BUS_WIDTH-1:0]                 D;
  logic                                 regWrite;
  logic                                 done;
  logic                                 zero;
  logic                                 carry;

  // Execute unit side
  modport slave (
    input  instr_valid, opcode, rd_in, rsA_in, rsB_in, A, B,
    output instr_ready, rsA, rsB, rd, D, regWrite, done, zero, carry
  );

  // Decoder / register file side
  modport master (
    output instr_valid, opcode, rd_in, rsA_in, rsB_in, A, B,
    input  instr_ready, rsA, rsB, rd, D, regWrite, done, zero, carry
  );

endinterface

// File: rtl/rf_exec_mul.sv
// Sequential shift-add multiplier: one multiplier bit per clock, BUS_WIDTH iterations.
// product presents the accumulator including the current iteration's addend, so on
// the cycle 'last' is high it already holds the final product.
module rf_exec_mul #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUS_WIDTH-1:0]   a,
  input  logic [BUS_WIDTH-1:0]   b,
  output logic                   busy,
  output logic                   last,
  output logic [2*BUS_WIDTH-1:0] product
);

  localparam int              CNT_W    = $clog2(BUS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

  logic [2*BUS_WIDTH-1:0] r_mcand;
  logic [2*BUS_WIDTH-1:0] r_acc;
  logic [BUS_WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic [2*BUS_WIDTH-1:0] w_addend;
  logic [2*BUS_WIDTH-1:0] w_sum;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

  // Load operands on start, then shift-add once per edge until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{BUS_WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign last    = r_busy && (r_cnt == CNT_LAST);
  assign product = w_sum;

endmodule

// File: rtl/rf_exec_unit.sv
// Execute/writeback sequencer around the register file.
//   state | meaning
//   IDLE  | ready for a decoded instruction
//   READ  | register file registering A/B from rsA/rsB
//   EXEC  | ALU result registered, or multiplier started for MUL
//   MUL   | shift-add iterations in progress
//   WB    | regWrite/done high; next edge commits and updates flags
module rf_exec_unit
  import rf_exec_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  rf_exec_if.slave bus
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  opcode_e                r_op;
  logic [REG_IDX_W-1:0]   r_rd_lat;
  logic [REG_IDX_W-1:0]   r_rsa;
  logic [REG_IDX_W-1:0]   r_rsb;
  logic [REG_IDX_W-1:0]   r_rd;
  logic [BUS_WIDTH-1:0]   r_d;
  logic                   r_reg_write;
  logic                   r_zero;
  logic                   r_carry;
  logic                   r_carry_pend;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_exec_alu;
  logic                   w_mul_start;
  logic                   w_mul_done;
  logic                   w_commit;
  logic                   w_mul_busy;
  logic                   w_mul_last;
  logic [2*BUS_WIDTH-1:0] w_product;
  logic [BUS_WIDTH:0]     w_alu_res;

  rf_exec_mul #(.BUS_WIDTH(BUS_WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (w_mul_busy),
    .last    (w_mul_last),
    .product (w_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_exec_alu  = 1'b0;
    w_mul_start = 1'b0;
    w_mul_done  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (r_op == OP_MUL) begin
          w_mul_start = 1'b1;
          w_state_nxt = ST_MUL;
        end else begin
          w_exec_alu  = 1'b1;
          w_state_nxt = ST_WB;
        end
      end
      ST_MUL: begin
        if (w_mul_last) begin
          w_mul_done  = 1'b1;
          w_state_nxt = ST_WB;
        end else if (!w_mul_busy) begin
          // multiplier lost its operation; drop the instruction rather than hang
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle ALU on the live A/B; bit BUS_WIDTH is carry-out for ADD, borrow for SUB.
  always_comb begin
    w_alu_res = '0;
    case (r_op)
      OP_ADD:  w_alu_res = {1'b0, bus.A} + {1'b0, bus.B};
      OP_SUB:  w_alu_res = {1'b0, bus.A} - {1'b0, bus.B};
      OP_AND:  w_alu_res = {1'b0, bus.A & bus.B};
      OP_OR:   w_alu_res = {1'b0, bus.A | bus.B};
      OP_XOR:  w_alu_res = {1'b0, bus.A ^ bus.B};
      OP_NOT:  w_alu_res = {1'b0, ~bus.A};
      OP_MOV:  w_alu_res = {1'b0, bus.A};
      default: w_alu_res = '0;
    endcase
  end

  // Instruction latch, write-port registers and flags; flags move only at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_ADD;
      r_rd_lat     <= '0;
      r_rsa        <= '0;
      r_rsb        <= '0;
      r_rd         <= '0;
      r_d          <= '0;
      r_reg_write  <= 1'b0;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_carry_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= opcode_e'(bus.opcode);
        r_rd_lat <= bus.rd_in;
        r_rsa    <= bus.rsA_in;
        r_rsb    <= bus.rsB_in;
      end
      if (w_exec_alu) begin
        r_d          <= w_alu_res[BUS_WIDTH-1:0];
        r_carry_pend <= w_alu_res[BUS_WIDTH];
        r_rd         <= r_rd_lat;
        r_reg_write  <= 1'b1;
      end
      if (w_mul_done) begin
        r_d          <= w_product[BUS_WIDTH-1:0];
        r_carry_pend <= |w_product[2*BUS_WIDTH-1:BUS_WIDTH];
        r_rd         <= r_rd_lat;
        r_reg_write  <= 1'b1;
      end
      if (w_commit) begin
        r_reg_write <= 1'b0;
        r_zero      <= (r_d == '0);
        r_carry     <= r_carry_pend;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.rsA         = r_rsa;
  assign bus.rsB         = r_rsb;
  assign bus.rd          = r_rd;
  assign bus.D           = r_d;
  assign bus.regWrite    = r_reg_write;
  assign bus.done        = r_reg_write;
  assign bus.zero        = r_zero;
  assign bus.carry       = r_carry;

endmodule

// File: tb/tb_rf_exec_unit.sv
// Bench for rf_exec_unit: behavioural register file, vector table, and hand-written
// back-to-back and reset-during-MUL sequences.
module tb_rf_exec_unit;
  import rf_exec_pkg::*;

  localparam int W = 16;

  typedef struct {
    opcode_e      op;
    logic [2:0]   rd;
    logic [2:0]   rsa;
    logic [2:0]   rsb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic         exp_z;
    logic         exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_exec_if #(.BUS_WIDTH(W)) bus();

  rf_exec_unit #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // register file model with a bench preload port
  logic [W-1:0] regs [8];
  logic         pl_en = 1'b0;
  logic [2:0]   pl_idx = '0;
  logic [W-1:0] pl_val = '0;
  always @(posedge clk) begin
    bus.A <= regs[bus.rsA];
    bus.B <= regs[bus.rsB];
    if (bus.regWrite) regs[bus.rd] <= bus.D;
    if (pl_en) regs[pl_idx] <= pl_val;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic wb_cnt_en = 1'b0;
  int   wb_cnt = 0;
  always @(negedge clk) if (wb_cnt_en && bus.regWrite) wb_cnt = wb_cnt + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_vec = 0;
  logic prev_z = 1'b0;
  logic prev_c = 1'b0;
  vec_t vecs [15];
  vec_t b2b [3];
  int   acc [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [W-1:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.opcode = v.op; bus.rd_in = v.rd; bus.rsA_in = v.rsa; bus.rsB_in = v.rsb;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    int    exp_lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    preload(v.rsa, v.a);
    preload(v.rsb, v.b);
    @(negedge clk);
    chk({nm, " ready idle"}, bus.instr_ready, 1);
    drive(v);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    chk({nm, " ready after accept"}, bus.instr_ready, 0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.regWrite) lat = k;
    end
    exp_lat = (v.op == OP_MUL) ? W + 3 : 3;
    chk({nm, " regWrite latency"}, lat, exp_lat);
    chk({nm, " D"}, bus.D, v.exp_d);
    chk({nm, " rd"}, bus.rd, v.rd);
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " zero before commit"}, bus.zero, prev_z);
    chk({nm, " carry before commit"}, bus.carry, prev_c);
    @(posedge clk);
    #1;
    chk({nm, " regWrite cleared"}, bus.regWrite, 0);
    chk({nm, " done cleared"}, bus.done, 0);
    chk({nm, " zero"}, bus.zero, v.exp_z);
    chk({nm, " carry"}, bus.carry, v.exp_c);
    chk({nm, " ready after commit"}, bus.instr_ready, 1);
    chk({nm, " regfile dest"}, regs[v.rd], v.exp_d);
    prev_z = v.exp_z;
    prev_c = v.exp_c;
    n_vec++;
  endtask

  initial begin
    logic got;
    logic seen_wr;

    vecs[0]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{OP_SUB, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
    vecs[2]  = '{OP_AND, 3'd5, 3'd1, 3'd2, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0};
    vecs[3]  = '{OP_OR,  3'd6, 3'd3, 3'd4, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0};
    vecs[4]  = '{OP_XOR, 3'd7, 3'd1, 3'd5, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0};
    vecs[5]  = '{OP_NOT, 3'd0, 3'd6, 3'd7, 16'h00FF, 16'h5555, 16'hFF00, 1'b0, 1'b0};
    vecs[6]  = '{OP_MOV, 3'd1, 3'd2, 3'd3, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b0, 1'b0};
    vecs[7]  = '{OP_MUL, 3'd3, 3'd1, 3'd2, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0};
    vecs[8]  = '{OP_MUL, 3'd4, 3'd1, 3'd2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{OP_ADD, 3'd5, 3'd6, 3'd7, 16'h7000, 16'h1000, 16'h8000, 1'b0, 1'b0};
    vecs[10] = '{OP_SUB, 3'd6, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    vecs[11] = '{OP_MUL, 3'd7, 3'd3, 3'd4, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1};
    vecs[12] = '{OP_SUB, 3'd0, 3'd5, 3'd6, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{OP_MOV, 3'd2, 3'd2, 3'd2, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[14] = '{OP_XOR, 3'd2, 3'd2, 3'd2, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

    b2b[0] = '{OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0, 16'h0, 16'h0030, 1'b0, 1'b0};
    b2b[1] = '{OP_ADD, 3'd6, 3'd5, 3'd5, 16'h0, 16'h0, 16'h0060, 1'b0, 1'b0};
    b2b[2] = '{OP_SUB, 3'd7, 3'd6, 3'd1, 16'h0, 16'h0, 16'h0050, 1'b0, 1'b0};

    bus.instr_valid = 1'b0;
    bus.opcode = 3'd0; bus.rd_in = '0; bus.rsA_in = '0; bus.rsB_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset regWrite", bus.regWrite, 0);
    chk("reset D", bus.D, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", bus.instr_ready, 1);
    chk("reset done", bus.done, 0);
    chk("reset rsA", bus.rsA, 0);
    chk("reset rsB", bus.rsB, 0);
    chk("reset rd", bus.rd, 0);
    chk("reset zero", bus.zero, 0);
    chk("reset carry", bus.carry, 0);
    for (int i = 0; i < 8; i++) preload(3'(i), '0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // back-to-back with instr_valid held high throughout
    preload(3'd1, 16'h0010);
    preload(3'd2, 16'h0020);
    @(negedge clk);
    wb_cnt = 0;
    wb_cnt_en = 1'b1;
    drive(b2b[0]);
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        if (bus.instr_ready) got = 1'b1;
        else @(negedge clk);
      end
      chk($sformatf("b2b accept %0d seen", k), got, 1);
      @(posedge clk);
      #1 acc[k] = cyc;
      @(negedge clk);
      chk($sformatf("b2b ready low after accept %0d", k), bus.instr_ready, 0);
      if (k < 2) drive(b2b[k+1]);
      else bus.instr_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    wb_cnt_en = 1'b0;
    chk("b2b accept spacing 0->1", acc[1] - acc[0], 4);
    chk("b2b accept spacing 1->2", acc[2] - acc[1], 4);
    chk("b2b regWrite cycles", wb_cnt, 3);
    chk("b2b R5", regs[5], 16'h0030);
    chk("b2b R6", regs[6], 16'h0060);
    chk("b2b R7", regs[7], 16'h0050);
    n_vec += 3;

    // reset in the middle of a multiply
    preload(3'd3, 16'h0003);
    preload(3'd4, 16'h0005);
    preload(3'd6, 16'hAAAA);
    @(negedge clk);
    drive('{OP_MUL, 3'd6, 3'd3, 3'd4, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0});
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    chk("rst-mul rsA driven", bus.rsA, 3);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst-mul regWrite", bus.regWrite, 0);
    chk("rst-mul done", bus.done, 0);
    chk("rst-mul D", bus.D, 0);
    chk("rst-mul rsA", bus.rsA, 0);
    chk("rst-mul rsB", bus.rsB, 0);
    chk("rst-mul rd", bus.rd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst-mul ready after release", bus.instr_ready, 1);
    seen_wr = 1'b0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (bus.regWrite) seen_wr = 1'b1;
    end
    chk("rst-mul no late write", seen_wr, 0);
    chk("rst-mul dest unchanged", regs[6], 16'hAAAA);
    n_vec++;

    // unit still works after the dropped instruction
    prev_z = 1'b0;
    prev_c = 1'b0;
    run_vec('{OP_MUL, 3'd6, 3'd3, 3'd4, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
